// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response channel between the pipeline Memory stage (master) and the
// data-memory responder (slave).
//   Request : reqValid, reqReady, reqWrite, reqAddr, reqSize, reqUnsigned,
//             reqWriteData
//   Response: respValid, respReady, respData, respError
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqWriteData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respData;
  logic        respError;

  modport master (
    output reqValid, reqWrite, reqAddr, reqSize, reqUnsigned, reqWriteData,
    output respReady,
    input  reqReady, respValid, respData, respError
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqSize, reqUnsigned, reqWriteData,
    input  respReady,
    output reqReady, respValid, respData, respError
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder. Accepts one load/store at a time,
// commits stores / samples loads on the acceptance edge and presents the
// response a fixed LATENCY cycles later, holding it until consumed.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dmem_responder_if.slave (request and response channels)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (byte addresses 0..DEPTH_WORDS*4-1)
//   LATENCY     : acceptance-to-response latency, 1..15
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One extra bit so the limit cannot wrap for the largest depths.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  logic [1:0]      state_reg;
  logic [3:0]      cnt_reg;
  logic            resp_err_reg;
  logic            resp_load_reg;   // response carries load data
  logic [1:0]      size_reg;
  logic [1:0]      lane_reg;
  logic            uns_reg;

  logic            accept;
  logic            req_error;
  logic [AW-1:0]   word_idx;
  logic [3:0]      lane_we;
  logic [3:0][7:0] lane_wdata;
  logic            rd_en;
  logic [3:0][7:0] rd_word;

  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     load_val;

  assign accept   = (state_reg == ST_IDLE) && bus.reqValid;
  assign word_idx = bus.reqAddr[AW+1:2];

  // Request legality: size, natural alignment and address range.
  always_comb begin
    req_error = 1'b0;
    case (bus.reqSize)
      2'd1:    if (bus.reqAddr[0])         req_error = 1'b1;
      2'd2:    if (bus.reqAddr[1:0] != 2'b00) req_error = 1'b1;
      2'd3:    req_error = 1'b1;
      default: req_error = 1'b0;
    endcase
    if ({1'b0, bus.reqAddr} >= ADDR_LIMIT) req_error = 1'b1;
  end

  // Byte-lane write enables and data for the little-endian store.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = bus.reqWriteData;
    if (accept && bus.reqWrite && !req_error) begin
      case (bus.reqSize)
        2'd0: begin
          lane_we[bus.reqAddr[1:0]] = 1'b1;
          lane_wdata                = {4{bus.reqWriteData[7:0]}};
        end
        2'd1: begin
          lane_we[{bus.reqAddr[1], 1'b0}] = 1'b1;
          lane_we[{bus.reqAddr[1], 1'b1}] = 1'b1;
          lane_wdata                      = {2{bus.reqWriteData[15:0]}};
        end
        default: begin
          lane_we    = 4'b1111;
          lane_wdata = bus.reqWriteData;
        end
      endcase
    end
  end

  assign rd_en = accept && !bus.reqWrite && !req_error;

  // One byte-wide RAM per lane; the read register only loads on an accepted
  // load so it holds the sampled word for the whole response.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clock) begin
        if (lane_we[gi]) mem[word_idx] <= lane_wdata[gi];
        if (rd_en)       rd_byte_reg   <= mem[word_idx];
      end
    end
  endgenerate

  assign rd_word = {g_lane[3].rd_byte_reg, g_lane[2].rd_byte_reg,
                    g_lane[1].rd_byte_reg, g_lane[0].rd_byte_reg};

  // Control FSM and response attribute registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      resp_err_reg  <= 1'b0;
      resp_load_reg <= 1'b0;
      size_reg      <= 2'd0;
      lane_reg      <= 2'd0;
      uns_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.reqValid) begin
            resp_err_reg  <= req_error;
            resp_load_reg <= !bus.reqWrite && !req_error;
            size_reg      <= bus.reqSize;
            lane_reg      <= bus.reqAddr[1:0];
            uns_reg       <= bus.reqUnsigned;
            cnt_reg       <= 4'(LATENCY - 1);
            state_reg     <= (LATENCY > 1) ? ST_WAIT : ST_RESPOND;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          // <= guards against a stuck zero count.
          if (cnt_reg <= 4'd1) state_reg <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (bus.respReady) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Lane select and extension of the sampled word. Only registered values
  // feed this, so respData is stable for the whole response.
  always_comb begin
    sel_byte = rd_word[lane_reg];
    sel_half = lane_reg[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
    load_val = rd_word;
    case (size_reg)
      2'd0:    load_val = {{24{!uns_reg & sel_byte[7]}}, sel_byte};
      2'd1:    load_val = {{16{!uns_reg & sel_half[15]}}, sel_half};
      default: load_val = rd_word;
    endcase
  end

  assign bus.reqReady  = (state_reg == ST_IDLE);
  assign bus.respValid = (state_reg == ST_RESPOND);
  assign bus.respError = resp_err_reg;
  assign bus.respData  = resp_load_reg ? load_val : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench: directed vector table, backpressure and mid-operation
// reset sequences, randomized traffic against a byte-array reference model,
// and a LATENCY=1 instance driven back to back.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);
  localparam int          DEPTH1 = 64;

  logic clock;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t       vecs [16];
  logic [7:0] model_mem [0:4095];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: little-endian byte array, natural alignment, range limit.
  task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output logic [31:0] data, output logic err);
    int n;
    logic [31:0] v;
    n    = 1 << size;
    err  = (size == 2'd3) || ((addr % n) != 0) || (addr >= LIMIT);
    data = 32'd0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(addr) + i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        data = v;
      end
    end
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input int hold,
                        output logic [31:0] data, output logic err, output int lat,
                        output bit ok);
    bit rdy;
    ok = 0; lat = 0; data = 32'd0; err = 1'b0; rdy = 0;
    @(negedge clock);
    for (int i = 0; i < 50; i++) begin
      if (bus.reqReady) begin rdy = 1; break; end
      @(negedge clock);
    end
    if (rdy) begin
      bus.reqWrite     = wr;
      bus.reqAddr      = addr;
      bus.reqSize      = size;
      bus.reqUnsigned  = uns;
      bus.reqWriteData = wdata;
      bus.reqValid     = 1'b1;
      @(posedge clock);
      #1 bus.reqValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        lat++;
        if (bus.respValid) begin ok = 1; break; end
      end
      if (ok) begin
        data = bus.respData;
        err  = bus.respError;
        repeat (hold) @(negedge clock);
        bus.respReady = 1'b1;
        @(posedge clock);
        #1 bus.respReady = 1'b0;
      end
    end
  endtask

  task automatic reset_mid(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    bus.reqWrite     = wr;
    bus.reqAddr      = addr;
    bus.reqSize      = 2'd2;
    bus.reqUnsigned  = 1'b0;
    bus.reqWriteData = wdata;
    bus.reqValid     = 1'b1;
    @(posedge clock);
    #1 bus.reqValid = 1'b0;
    @(negedge clock);
    check("rst_in_wait_ready", 32'(bus.reqReady), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.respValid), 32'd0);
    check("rst_async_ready", 32'(bus.reqReady), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("rst_no_resp", 32'(bus.respValid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] d, md, d0, w1 [4];
    logic        e, me, found;
    int          lat, prev, acc;
    bit          ok;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        wr, un;

    total = 0; bad = 0; cyc = 0;
    reset = 1'b0;
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqAddr = 32'd0; bus.reqSize = 2'd0;
    bus.reqUnsigned = 1'b0; bus.reqWriteData = 32'd0; bus.respReady = 1'b0;
    bus1.reqValid = 1'b0; bus1.reqWrite = 1'b0; bus1.reqAddr = 32'd0; bus1.reqSize = 2'd2;
    bus1.reqUnsigned = 1'b0; bus1.reqWriteData = 32'd0; bus1.respReady = 1'b1;

    vecs[0]  = '{1'b1, 32'h10,  2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, "st_w_10"};
    vecs[1]  = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, "ld_w_10"};
    vecs[2]  = '{1'b1, 32'h11,  2'd0, 1'b0, 32'h00000080, 32'h00000000, 1'b0, "st_b_11"};
    vecs[3]  = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0, "ld_w_after_b"};
    vecs[4]  = '{1'b0, 32'h11,  2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, "ld_bs_11"};
    vecs[5]  = '{1'b0, 32'h11,  2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0, "ld_bu_11"};
    vecs[6]  = '{1'b0, 32'h12,  2'd1, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0, "ld_hs_12"};
    vecs[7]  = '{1'b0, 32'h13,  2'd2, 1'b0, 32'h0,        32'h00000000, 1'b1, "ld_w_mis"};
    vecs[8]  = '{1'b1, 32'h11,  2'd1, 1'b0, 32'h00001234, 32'h00000000, 1'b1, "st_h_mis"};
    vecs[9]  = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0, "ld_w_unchg"};
    vecs[10] = '{1'b0, LIMIT,   2'd2, 1'b0, 32'h0,        32'h00000000, 1'b1, "ld_w_oor"};
    vecs[11] = '{1'b1, LIMIT,   2'd0, 1'b0, 32'h000000AA, 32'h00000000, 1'b1, "st_b_oor"};
    vecs[12] = '{1'b0, 32'h10,  2'd3, 1'b0, 32'h0,        32'h00000000, 1'b1, "ld_size3"};
    vecs[13] = '{1'b1, 32'h12,  2'd1, 1'b0, 32'h0000CAFE, 32'h00000000, 1'b0, "st_h_12"};
    vecs[14] = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'hCAFE80EF, 1'b0, "ld_w_after_h"};
    vecs[15] = '{1'b0, 32'h12,  2'd1, 1'b1, 32'h0,        32'h0000CAFE, 1'b0, "ld_hu_12"};

    repeat (3) @(negedge clock);
    check("reset_reqReady",  32'(bus.reqReady),  32'd1);
    check("reset_respValid", 32'(bus.respValid), 32'd0);
    check("reset_respData",  bus.respData,       32'd0);
    check("reset_respError", 32'(bus.respError), 32'd0);
    reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, 0, d, e, lat, ok);
      $display("vec %0d %s: data=%h err=%0d lat=%0d", i, vecs[i].name, d, e, lat);
      check({vecs[i].name, "_done"}, 32'(ok), 32'd1);
      check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
      check({vecs[i].name, "_err"},  32'(e), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"},  32'(lat), 32'd2);
    end

    // Backpressure, with a competing store held while not ready.
    @(negedge clock);
    bus.reqWrite = 1'b0; bus.reqAddr = 32'h10; bus.reqSize = 2'd2; bus.reqUnsigned = 1'b0;
    bus.reqValid = 1'b1;
    @(posedge clock);
    #1 bus.reqWrite = 1'b1; bus.reqWriteData = 32'h11111111;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.respValid) begin found = 1'b1; break; end
    end
    check("bp_resp_seen", 32'(found), 32'd1);
    d0 = bus.respData;
    check("bp_data", d0, 32'hCAFE80EF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("bp_hold_valid", 32'(bus.respValid), 32'd1);
      check("bp_hold_data",  bus.respData, d0);
      check("bp_hold_ready", 32'(bus.reqReady), 32'd0);
    end
    bus.reqValid  = 1'b0;
    bus.respReady = 1'b1;
    check("bp_consume_cycle_ready", 32'(bus.reqReady), 32'd0);
    @(posedge clock);
    #1 bus.respReady = 1'b0;
    @(negedge clock);
    check("bp_after_ready", 32'(bus.reqReady), 32'd1);
    check("bp_after_valid", 32'(bus.respValid), 32'd0);
    $display("backpressure: held data=%h", d0);
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, d, e, lat, ok);
    $display("reload 0x10: data=%h", d);
    check("bp_ignored_store", d, 32'hCAFE80EF);

    // Reset while a load, then a store, is in WAIT.
    reset_mid(1'b0, 32'h10, 32'h0);
    $display("reset during load wait");
    reset_mid(1'b1, 32'h20, 32'h5A5A1234);
    $display("reset during store wait");
    do_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, d, e, lat, ok);
    $display("load 0x20 after reset: data=%h err=%0d", d, e);
    check("rst_store_committed", d, 32'h5A5A1234);

    // Randomized traffic against the model, region 0x100..0x1FF.
    for (int i = 0; i < 64; i++) begin
      a  = 32'h100 + 32'(4 * i);
      wd = $urandom;
      model_txn(1'b1, a, 2'd2, 1'b0, wd, md, me);
      do_txn(1'b1, a, 2'd2, 1'b0, wd, 0, d, e, lat, ok);
      check("init_err", 32'(e), 32'(me));
    end
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) a = LIMIT + 32'($urandom_range(0, 15));
      else                           a = 32'h100 + 32'($urandom_range(0, 255));
      model_txn(wr, a, sz, un, wd, md, me);
      do_txn(wr, a, sz, un, wd, $urandom_range(0, 3), d, e, lat, ok);
      $display("rnd %0d: wr=%0d addr=%h size=%0d uns=%0d data=%h err=%0d lat=%0d",
               i, wr, a, sz, un, d, e, lat);
      check("rnd_done", 32'(ok), 32'd1);
      check("rnd_data", d, md);
      check("rnd_err",  32'(e), 32'(me));
      check("rnd_lat",  32'(lat), 32'd2);
    end

    // LATENCY=1 instance: back-to-back requests, respReady tied high.
    for (int i = 0; i < 4; i++) w1[i] = $urandom;
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      bus1.reqWrite     = (i < 4);
      bus1.reqAddr      = 32'(4 * (i % 4));
      bus1.reqSize      = 2'd2;
      bus1.reqWriteData = w1[i % 4];
      bus1.reqValid     = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clock);
        if (bus1.reqReady) begin found = 1'b1; break; end
      end
      check("l1_ready", 32'(found), 32'd1);
      @(posedge clock);
      #1 acc = cyc;
      if (i > 0) check("l1_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
      @(negedge clock);
      $display("lat1 %0d: wr=%0d addr=%h valid=%0d data=%h", i, (i < 4), 32'(4 * (i % 4)),
               bus1.respValid, bus1.respData);
      check("l1_valid", 32'(bus1.respValid), 32'd1);
      check("l1_data",  bus1.respData, (i < 4) ? 32'd0 : w1[i % 4]);
      check("l1_err",   32'(bus1.respError), 32'd0);
    end
    bus1.reqValid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the load/store requests issued by the pipeline's Memory stage over a valid/ready request channel and a valid/ready response channel. It holds one outstanding transaction at a time and returns the response after a fixed, parameterised latency. It performs byte/halfword/word access with little-endian lane selection, load sign/zero extension and alignment/range checking. It sits beside the Memory stage, which stalls while a request is outstanding.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; valid byte addresses are 0 .. DEPTH_WORDS*4-1
- LATENCY, 2, cycles from request acceptance to respValid; legal range 1..15
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- reqValid  in  1  request present
- reqReady  out  1  responder can accept; high only in IDLE
- reqWrite  in  1  1 = store, 0 = load
- reqAddr  in  32  byte address
- reqSize  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal (error)
- reqUnsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- reqWriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- respValid  out  1  response present
- respReady  in  1  consumer takes the response
- respData  out  32  load result, extended to 32 bits; 0 for stores and errors
- respError  out  1  misaligned, out-of-range, or illegal size

## Operation
- States: IDLE, WAIT, RESPOND.
- IDLE: reqReady=1. When reqValid=1, the request is accepted on the next rising edge.
- On the acceptance edge:
  - Error check runs first. Error if reqSize=3, or halfword with addr[0]≠0, or word with addr[1:0]≠0, or addr ≥ DEPTH_WORDS*4.
  - Store without error: memory is written at this edge.
    - byte → lane addr[1:0] gets data[7:0]
    - half → lanes {addr[1],0} and {addr[1],1} get data[7:0] and data[15:0] upper byte
    - word → all four lanes
    - Other lanes are untouched.
  - Load without error: the addressed word is sampled at this edge.
    - byte → lane addr[1:0]
    - half → bytes addr[1]*2 (low) and addr[1]*2+1 (high)
    - Result extended per reqUnsigned.
  - Result and error flag are latched into the response registers.
  - Next state: WAIT if LATENCY>1, else RESPOND.
  - Latency counter loads LATENCY-1.
- WAIT: the counter decrements each edge. Moves to RESPOND on the edge where the counter reaches 1→0.
- RESPOND: respValid=1; respData and respError are held stable. When respReady=1, the response is consumed on that edge and the state returns to IDLE.
- Errored requests never modify memory. They return respError=1 with respData=0 and take the same latency.
- Memory array contents are not cleared by reset.

## Timing
- Reset values: state=IDLE, reqReady=1, respValid=0, respData=0, respError=0, counter=0.
- Latency: a request accepted at edge k gives respValid=1 after edge k+LATENCY. Exactly LATENCY cycles when respReady is held high.
- Throughput: at most one transaction per LATENCY+1 cycles. reqReady=0 during WAIT and RESPOND, including the cycle in which the response is consumed. The next acceptance happens no earlier than the edge after consumption.
- reqValid while reqReady=0 is ignored. The requester must hold the request; no request state changes.
- A store followed by a load to the same address returns the stored data, because the write commits at acceptance.
- Reset asserted mid-WAIT or mid-RESPOND:
  - Returns to IDLE immediately (asynchronous); the pending response is dropped.
  - A store already accepted remains committed.
- respReady asserted outside RESPOND has no effect.

## Test plan
- Reset, then word store 0xDEADBEEF @0x10 followed by word load @0x10. Store response: respError=0, respData=0. Load response: 0xDEADBEEF, with respValid exactly 2 cycles after acceptance (LATENCY=2).
- After the above:
  - byte store 0x80 @0x11 → word load @0x10 gives 0xDEAD80EF
  - signed byte load @0x11 gives 0xFFFFFF80
  - unsigned byte load @0x11 gives 0x00000080
  - signed half load @0x12 gives 0xFFFFDEAD
- Error cases:
  - word load @0x13 → respError=1, respData=0
  - half store @0x11 → respError=1, and memory is unchanged (a word re-read at 0x10 is unchanged)
  - any access @DEPTH_WORDS*4 → respError=1
  - reqSize=3 → respError=1
- Backpressure: hold respReady=0 for 5 cycles after respValid. respValid and respData must stay stable and reqReady must stay 0. Raise respReady: reqReady returns to 1 on the following cycle.
- Reset mid-operation: accept a load, assert reset in WAIT. respValid=0 and reqReady=1 immediately. No response appears after reset is released.
- LATENCY=1 build: back-to-back loads with respReady tied high. Each response appears 1 cycle after acceptance, and accepts are spaced 2 cycles apart.
